// File: rtl/event_counter_pkg.sv
// Shared digit type, radix limits and per-digit step helpers for the event counter.
package event_counter_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t DEC_MAX = 4'd9;
    localparam digit_t HEX_MAX = 4'hF;

    function automatic digit_t digit_max(input logic mode_dec);
        return mode_dec ? DEC_MAX : HEX_MAX;
    endfunction

    // Returns {carry, next_digit}.
    function automatic logic [4:0] digit_inc(input digit_t d, input logic mode_dec);
        if (d >= digit_max(mode_dec)) begin
            return {1'b1, 4'd0};
        end
        return {1'b0, d + 4'd1};
    endfunction

    // Returns {borrow, next_digit}.
    function automatic logic [4:0] digit_dec(input digit_t d, input logic mode_dec);
        if (d == 4'd0) begin
            return {1'b1, digit_max(mode_dec)};
        end
        return {1'b0, d - 4'd1};
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One multi-digit up/down counter with radix select, wrap/saturate policy and sticky limit flag.
module counter_channel
    import event_counter_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        inc,
    input  logic                        dec,
    input  logic                        clr,
    input  logic                        mode_dec,
    output digit_t [NUM_DIGITS-1:0]     count,
    output logic                        wrapped
);

    digit_t [NUM_DIGITS-1:0] count_q, count_d, inc_val, dec_val;
    logic                    wrapped_q, wrapped_d;
    logic                    mode_q;
    logic                    carry, borrow;
    logic [4:0]              inc_step, dec_step;

    // Full ripple through every digit; carry/borrow out of the top digit marks a limit hit.
    always_comb begin
        inc_val  = count_q;
        dec_val  = count_q;
        carry    = 1'b1;
        borrow   = 1'b1;
        inc_step = '0;
        dec_step = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            inc_step = digit_inc(count_q[i], mode_q);
            dec_step = digit_dec(count_q[i], mode_q);
            if (carry) begin
                inc_val[i] = inc_step[3:0];
                carry      = inc_step[4];
            end
            if (borrow) begin
                dec_val[i] = dec_step[3:0];
                borrow     = dec_step[4];
            end
        end
    end

    always_comb begin
        count_d   = count_q;
        wrapped_d = wrapped_q;
        if (clr || (mode_dec != mode_q)) begin
            count_d   = '0;
            wrapped_d = 1'b0;
        end else if (inc && dec) begin
            count_d = count_q;
        end else if (inc) begin
            if (carry) wrapped_d = 1'b1;
            if (!(carry && SATURATE)) count_d = inc_val;
        end else if (dec) begin
            if (borrow) wrapped_d = 1'b1;
            if (!(borrow && SATURATE)) count_d = dec_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            mode_q    <= mode_dec;
        end
    end

    assign count   = count_q;
    assign wrapped = wrapped_q;

endmodule

// File: rtl/multi_channel_event_counter.sv
// NUM_CH independent event counters with one channel paged onto a registered display bus.
module multi_channel_event_counter
    import event_counter_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned NUM_DIGITS = 4,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic                        clk,
    input  logic                        CPU_RESETN,
    input  logic [NUM_CH-1:0]           inc,
    input  logic [NUM_CH-1:0]           dec,
    input  logic [NUM_CH-1:0]           clr,
    input  logic [NUM_CH-1:0]           mode_dec,
    input  logic                        page_next,
    output logic [NUM_DIGITS-1:0][3:0]  encoded,
    output logic [NUM_DIGITS-1:0]       digit_point,
    output logic [$clog2(NUM_CH)-1:0]   page,
    output logic [NUM_CH-1:0]           wrapped
);

    localparam int unsigned PAGE_W = $clog2(NUM_CH);

    digit_t [NUM_DIGITS-1:0] ch_count [NUM_CH];
    logic [PAGE_W-1:0]       page_q, page_d;
    logic [NUM_DIGITS-1:0][3:0] encoded_q;
    logic [NUM_DIGITS-1:0]   digit_point_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        counter_channel #(
            .NUM_DIGITS (NUM_DIGITS),
            .SATURATE   (SATURATE)
        ) u_channel (
            .clk      (clk),
            .rst_n    (CPU_RESETN),
            .inc      (inc[g]),
            .dec      (dec[g]),
            .clr      (clr[g]),
            .mode_dec (mode_dec[g]),
            .count    (ch_count[g]),
            .wrapped  (wrapped[g])
        );
    end

    always_comb begin
        page_d = page_q;
        if (page_next) begin
            page_d = (page_q == PAGE_W'(NUM_CH - 1)) ? '0 : page_q + 1'b1;
        end
    end

    // Display mux uses the registered page, so a new page shows one edge after it is taken.
    always_ff @(posedge clk) begin
        if (!CPU_RESETN) begin
            page_q        <= '0;
            encoded_q     <= '0;
            digit_point_q <= NUM_DIGITS'(1);
        end else begin
            page_q        <= page_d;
            encoded_q     <= ch_count[page_q];
            digit_point_q <= NUM_DIGITS'(1) << page_q;
        end
    end

    assign page        = page_q;
    assign encoded     = encoded_q;
    assign digit_point = digit_point_q;

endmodule

// File: tb/tb_multi_channel_event_counter.sv
// Wrap and saturate instances driven in parallel, checked each cycle against an arithmetic model.
module tb_multi_channel_event_counter;

    localparam int NUM_CH = 4;
    localparam int ND     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic [NUM_CH-1:0] inc, dec, clr, mode_dec;
    logic              page_next;

    logic [ND-1:0][3:0] enc_w, enc_s;
    logic [ND-1:0]      dp_w, dp_s;
    logic [1:0]         page_w, page_s;
    logic [NUM_CH-1:0]  wr_w, wr_s;

    multi_channel_event_counter #(
        .NUM_CH (NUM_CH), .NUM_DIGITS (ND), .SATURATE (1'b0)
    ) dut_wrap (
        .clk (clk), .CPU_RESETN (rstn), .inc (inc), .dec (dec), .clr (clr),
        .mode_dec (mode_dec), .page_next (page_next), .encoded (enc_w),
        .digit_point (dp_w), .page (page_w), .wrapped (wr_w)
    );

    multi_channel_event_counter #(
        .NUM_CH (NUM_CH), .NUM_DIGITS (ND), .SATURATE (1'b1)
    ) dut_sat (
        .clk (clk), .CPU_RESETN (rstn), .inc (inc), .dec (dec), .clr (clr),
        .mode_dec (mode_dec), .page_next (page_next), .encoded (enc_s),
        .digit_point (dp_s), .page (page_s), .wrapped (wr_s)
    );

    // Model state: counts as plain integers; index 0 = wrap policy, 1 = saturate policy.
    int unsigned m_cnt [2][NUM_CH];
    bit          m_wr  [2][NUM_CH];
    bit          m_mode[NUM_CH];
    int          m_page;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned limit_of(input bit dec_mode);
        int unsigned v = 1;
        for (int i = 0; i < ND; i++) v = v * (dec_mode ? 10 : 16);
        return v - 1;
    endfunction

    function automatic logic [ND*4-1:0] to_digits(input int unsigned v, input bit dec_mode);
        logic [ND*4-1:0] r = '0;
        int unsigned base = dec_mode ? 10 : 16;
        for (int i = 0; i < ND; i++) begin
            r[i*4 +: 4] = 4'(v % base);
            v = v / base;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = 1'b0;
            for (int s = 0; s < 2; s++) begin
                m_cnt[s][c] = 0;
                m_wr[s][c]  = 1'b0;
            end
        end
        m_page = 0;
    endtask

    // One clock edge: advance the model with the inputs sampled there, then compare.
    task automatic step();
        logic [ND*4-1:0] exp_enc [2];
        logic [ND-1:0]   exp_dp;
        logic [NUM_CH-1:0] exp_wr [2];
        int unsigned lim;
        @(posedge clk);
        if (!rstn) begin
            model_reset();
            exp_enc[0] = '0;
            exp_enc[1] = '0;
            exp_dp     = ND'(1);
        end else begin
            for (int s = 0; s < 2; s++) exp_enc[s] = to_digits(m_cnt[s][m_page], m_mode[m_page]);
            exp_dp = ND'(1) << m_page;
            for (int c = 0; c < NUM_CH; c++) begin
                lim = limit_of(m_mode[c]);
                for (int s = 0; s < 2; s++) begin
                    if (clr[c] || (mode_dec[c] != m_mode[c])) begin
                        m_cnt[s][c] = 0;
                        m_wr[s][c]  = 1'b0;
                    end else if (inc[c] && dec[c]) begin
                        m_cnt[s][c] = m_cnt[s][c];
                    end else if (inc[c]) begin
                        if (m_cnt[s][c] == lim) begin
                            m_wr[s][c] = 1'b1;
                            if (s == 0) m_cnt[s][c] = 0;
                        end else begin
                            m_cnt[s][c] = m_cnt[s][c] + 1;
                        end
                    end else if (dec[c]) begin
                        if (m_cnt[s][c] == 0) begin
                            m_wr[s][c] = 1'b1;
                            if (s == 0) m_cnt[s][c] = lim;
                        end else begin
                            m_cnt[s][c] = m_cnt[s][c] - 1;
                        end
                    end
                end
                m_mode[c] = mode_dec[c];
            end
            if (page_next) m_page = (m_page + 1) % NUM_CH;
        end
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < NUM_CH; c++) exp_wr[s][c] = m_wr[s][c];
        #1;
        check_eq("enc_wrap",  32'(enc_w),  32'(exp_enc[0]));
        check_eq("enc_sat",   32'(enc_s),  32'(exp_enc[1]));
        check_eq("dp_wrap",   32'(dp_w),   32'(exp_dp));
        check_eq("dp_sat",    32'(dp_s),   32'(exp_dp));
        check_eq("page_wrap", 32'(page_w), 32'(m_page));
        check_eq("page_sat",  32'(page_s), 32'(m_page));
        check_eq("wr_wrap",   32'(wr_w),   32'(exp_wr[0]));
        check_eq("wr_sat",    32'(wr_s),   32'(exp_wr[1]));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_inc(input int ch, input int n);
        repeat (n) begin
            inc = NUM_CH'(1) << ch;
            step();
        end
        inc = '0;
    endtask

    task automatic do_page(input int n);
        repeat (n) begin
            page_next = 1'b1;
            step();
        end
        page_next = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; inc = '0; dec = '0; clr = '0; mode_dec = '0; page_next = 1'b0;
        model_reset();
        idle(2);
        check_eq("rst_enc", 32'(enc_w), 32'h0);
        check_eq("rst_dp",  32'(dp_w),  32'h1);
        rstn = 1'b1;

        // 12 DEC increments on ch0
        mode_dec = 4'b0001;
        idle(1);
        do_inc(0, 12);
        idle(2);
        check_eq("dec12_enc", 32'(enc_w), 32'h0012);
        check_eq("dec12_wr",  32'(wr_w[0]), 32'h0);

        // 12 HEX increments on ch1, then page to it
        do_inc(1, 12);
        do_page(1);
        idle(1);
        check_eq("hex12_page", 32'(page_w), 32'h1);
        check_eq("hex12_dp",   32'(dp_w),   32'h2);
        check_eq("hex12_enc",  32'(enc_w),  32'h000C);
        do_page(3);
        idle(1);

        // Lower limit on DEC ch0
        clr = 4'b0001; step(); clr = '0;
        dec = 4'b0001; step(); dec = '0;
        idle(1);
        check_eq("under_enc_wrap", 32'(enc_w), 32'h9999);
        check_eq("under_wr_wrap",  32'(wr_w[0]), 32'h1);
        check_eq("under_enc_sat",  32'(enc_s), 32'h0000);
        check_eq("under_wr_sat",   32'(wr_s[0]), 32'h1);
        do_inc(0, 1);
        idle(1);
        check_eq("over_enc_wrap", 32'(enc_w), 32'h0000);

        // inc+dec together, then clr+inc together on ch2
        do_inc(2, 3);
        inc = 4'b0100; dec = 4'b0100;
        repeat (5) step();
        inc = '0; dec = '0;
        do_page(2);
        idle(1);
        check_eq("incdec_enc", 32'(enc_w), 32'h0003);
        clr = 4'b0100; inc = 4'b0100; step(); clr = '0; inc = '0;
        idle(1);
        check_eq("clrinc_enc", 32'(enc_w), 32'h0000);
        check_eq("clrinc_wr",  32'(wr_w[2]), 32'h0);
        do_page(2);

        // Mode toggle at 0x3A discards the inc in the same cycle
        mode_dec[0] = 1'b0; step();
        do_inc(0, 58);
        idle(2);
        check_eq("hex3a_enc", 32'(enc_w), 32'h003A);
        mode_dec[0] = 1'b1; inc = 4'b0001; step(); inc = '0;
        idle(1);
        check_eq("mode_clr_enc", 32'(enc_w), 32'h0000);

        do_page(NUM_CH);
        idle(1);
        check_eq("page_round", 32'(page_w), 32'h0);

        // Reset in the middle of a count burst
        inc = 4'b0001; idle(3);
        rstn = 1'b0; step();
        check_eq("midrst_enc", 32'(enc_w), 32'h0);
        check_eq("midrst_dp",  32'(dp_w),  32'h1);
        rstn = 1'b1; inc = '0;
        idle(1);

        // Back-to-back increments to the DEC upper limit on ch3, one past
        mode_dec[3] = 1'b1; step();
        do_inc(3, 10000);
        do_page(3);
        idle(1);
        check_eq("top_enc_sat",  32'(enc_s), 32'h9999);
        check_eq("top_wr_sat",   32'(wr_s[3]), 32'h1);
        check_eq("top_enc_wrap", 32'(enc_w), 32'h0000);
        check_eq("top_wr_wrap",  32'(wr_w[3]), 32'h1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                inc[c] = ($urandom_range(0, 3) == 0);
                dec[c] = ($urandom_range(0, 3) == 0);
                clr[c] = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 63) == 0) mode_dec[c] = ~mode_dec[c];
            end
            page_next = ($urandom_range(0, 7) == 0);
            rstn      = ($urandom_range(0, 999) != 0);
            step();
        end
        rstn = 1'b1; inc = '0; dec = '0; clr = '0; page_next = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_channel_event_counter.md
# multi_channel_event_counter

Parametrised successor to the two-display button counter top. Holds NUM_CH independent multi-digit event counters, each with increment, decrement and clear, a runtime-selectable HEX/DEC radix, and a wrap or saturate policy. One channel at a time is paged onto a `seven_segment`-compatible `encoded`/`digit_point` bus. Sits between the `button_debouncer` instances (single-cycle pulses) and the display driver.

## Interface
Parameters:
- NUM_CH, 4: number of counter channels; 2..NUM_DIGITS.
- NUM_DIGITS, 4: nibble digits per channel; also the display bus width.
- SATURATE, 0: 0 = wrap at limits, 1 = hold at limits.

Ports:
- clk  in  1  system clock.
- CPU_RESETN  in  1  reset; synchronous, active-low.
- inc  in  [NUM_CH]  per-channel increment pulse, one cycle wide.
- dec  in  [NUM_CH]  per-channel decrement pulse, one cycle wide.
- clr  in  [NUM_CH]  per-channel clear pulse.
- mode_dec  in  [NUM_CH]  level; 1 = BCD digits (0..9), 0 = hex digits (0..F).
- page_next  in  1  pulse; advances the displayed channel.
- encoded  out  [NUM_DIGITS-1:0][3:0]  digits of the displayed channel, registered.
- digit_point  out  [NUM_DIGITS-1:0]  one-hot page indicator, registered.
- page  out  $clog2(NUM_CH)  index of the displayed channel.
- wrapped  out  [NUM_CH]  sticky limit-event flag per channel.

## Operation
- Channel update priority, evaluated per channel per cycle:
  1. clr, or mode_dec differs from its registered copy mode_q (count goes to 0, wrapped goes to 0).
  2. inc and dec asserted together: no change.
  3. inc alone.
  4. dec alone.
- Increment:
  - Digit 0 +1. A digit at max (9 in DEC, F in HEX) goes to 0 and carries into the next digit.
  - Carry ripples through all digits within one cycle.
- Decrement: the mirror of increment. A digit at 0 goes to max and borrows from the next digit.
- Upper limit, all digits at max, plus inc:
  - SATURATE=0: count goes to all-zero.
  - SATURATE=1: count holds.
  - Either case: wrapped[ch] goes to 1.
- Lower limit, count 0 plus dec:
  - SATURATE=0: count goes to all-max.
  - SATURATE=1: count holds at 0.
  - Either case: wrapped[ch] goes to 1.
- wrapped stays set until clr or a mode change on that channel.
- Paging:
  - page_next increments page.
  - NUM_CH-1 wraps to 0.
- Display outputs:
  - encoded <= count[page].
  - digit_point <= one-hot at bit index page.
- Reset values, all outputs and state:
  - All counts 0; wrapped 0; mode_q 0; page 0.
  - encoded 0.
  - digit_point = 'b1 (bit 0 set).

## Timing
- inc/dec/clr sampled at edge N; count register updated at edge N; encoded reflects the new count after edge N+1. Two-cycle latency pulse-to-display.
- page_next at edge N: page updates at edge N. encoded and digit_point switch to the new channel at edge N+1.
- page_next coinciding with inc on the newly selected channel: display shows the post-increment value at edge N+1.
- mode_dec toggle sampled at edge N: count is 0 after edge N and encoded is 0 after edge N+1. An inc in that same cycle is discarded.
- Reset asserted mid-operation: all state returns to reset values on the next edge, regardless of pending pulses.
- Back-to-back inc pulses every cycle: each pulse counts, one per cycle. No pulse is dropped.

## Structure
- Package `event_counter_pkg` holds:
  - typedef `digit_t` (logic [3:0]).
  - constants `DEC_MAX` = 4'd9 and `HEX_MAX` = 4'hF.
  - functions `digit_inc` and `digit_dec` (digit, mode in; next digit and carry/borrow out).
- Sub-module `counter_channel`:
  - Holds one channel's count, mode_q and wrapped registers.
  - Parameters: NUM_DIGITS, SATURATE.
  - Instantiated NUM_CH times in a generate loop.
- Top holds the page register and the registered output mux.

## Test plan
- Reset release, then 12 inc on ch0 with mode_dec=1 → encoded = 0,0,1,2 (MSB→LSB) two cycles after the last pulse. wrapped[0]=0.
- Same 12 inc on ch1 with mode_dec=0, then one page_next → page=1, digit_point=4'b0010, encoded = 0,0,0,C.
- DEC ch0 preloaded to 9999 by decrement from 0:
  - SATURATE=0 run: first dec gives 9999 with wrapped=1; then inc gives 0000.
  - SATURATE=1 run: the first dec holds 0000 with wrapped=1.
- inc and dec asserted together on ch2 for 5 cycles → count unchanged. Then clr plus inc in the same cycle → count 0, wrapped 0.
- Toggle mode_dec[0] while count=0x3A → count 0 after one edge. An inc in the toggle cycle is ignored.
- page_next pulsed NUM_CH times → page returns to 0. Then CPU_RESETN pulled low for one cycle mid-count → all outputs equal their reset values on the next edge.
